// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and byte-lane select helper for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Unlisted encodings fall into the word case.
  function automatic logic [3:0] lsu_sel(input logic [2:0] funct3, input logic [1:0] a);
    case (funct3)
      LSU_B, LSU_BU: lsu_sel = 4'b0001 << a;
      LSU_H, LSU_HU: lsu_sel = a[1] ? 4'b1100 : 4'b0011;
      default:       lsu_sel = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load formatting: picks the addressed byte/halfword from a bus word and sign/zero extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      LSU_B:   result_o = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  result_o = {24'd0, byte_sel};
      LSU_H:   result_o = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  result_o = {16'd0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Execute-stage data-memory access engine: one bus transaction per request, lane steering and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses fault without a bus request instead of being aligned.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_sel,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  lsu_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          is_store_q, is_store_d;
  logic          fault_q, fault_d;

  logic [31:0]   req_addr;
  logic          req_trap;
  logic [31:0]   load_result;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    req_addr = i_addr;
    case (i_funct3)
      LSU_B, LSU_BU: req_trap = 1'b0;
      LSU_H, LSU_HU: req_trap = i_addr[0];
      default:       req_trap = |i_addr[1:0];
    endcase
  end
`else
  // Misaligned halfword/word requests are silently pulled down to natural alignment.
  always_comb begin
    req_trap = 1'b0;
    case (i_funct3)
      LSU_B, LSU_BU: req_addr = i_addr;
      LSU_H, LSU_HU: req_addr = {i_addr[31:1], 1'b0};
      default:       req_addr = {i_addr[31:2], 2'b00};
    endcase
  end
`endif

  lsu_load_align u_load_align (
    .rdata_i   (i_mem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .result_o  (load_result)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    funct3_d   = funct3_q;
    is_store_d = is_store_q;
    fault_d    = fault_q;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        fault_d = 1'b0;
        if (i_valid) begin
          addr_d     = req_addr;
          wdata_d    = i_wdata;
          funct3_d   = i_funct3;
          is_store_d = i_is_store;
          state_d    = req_trap ? DONE : REQ;
          fault_d    = req_trap;
        end
      end
      REQ: begin
        // An ack on the final timer cycle still completes the access cleanly.
        if (i_mem_ack) begin
          state_d = DONE;
          fault_d = 1'b0;
          if (!is_store_q) begin
            rdata_d = load_result;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d = DONE;
          fault_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        timer_d = '0;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        fault_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      funct3_q   <= funct3_d;
      is_store_q <= is_store_d;
      fault_q    <= fault_d;
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_done     = (state_q == DONE);
  assign o_fault    = (state_q == DONE) && fault_q;
  assign o_rdata    = rdata_q;
  assign o_mem_req  = (state_q == REQ);
  assign o_mem_we   = (state_q == REQ) && is_store_q;
  assign o_mem_addr = {addr_q[31:2], 2'b00};
  assign o_mem_sel  = (state_q == REQ) ? lsu_sel(funct3_q, addr_q[1:0]) : 4'b0000;

  always_comb begin
    case (funct3_q)
      LSU_B, LSU_BU: o_mem_wdata = {4{wdata_q[7:0]}};
      LSU_H, LSU_HU: o_mem_wdata = {2{wdata_q[15:0]}};
      default:       o_mem_wdata = wdata_q;
    endcase
  end

endmodule
